regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 16, register count; ADDR_W = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 4, combinational read ports.
REQ-004 SHALL have parameter NWR, default 3, write ports; port NWR-1 is the load-return port.
REQ-005 SHALL have parameter PC_W, default 11, PC field width; PC lives in register NREGS-1.
REQ-006 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-007 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port wr_en, input, NWR, per-port write enable.
REQ-010 SHALL have port wr_addr, input, NWR*ADDR_W, packed write addresses.
REQ-011 SHALL have port wr_data, input, NWR*DATA_W, packed write data.
REQ-012 SHALL have port rd_addr, input, NRD*ADDR_W, packed read addresses.
REQ-013 SHALL have port rd_data, output, NRD*DATA_W, packed read data.
REQ-014 SHALL have port rd_busy, output, NRD, read register has a pending load.
REQ-015 SHALL have port rsv_en / rsv_addr, input, 1 / ADDR_W, mark register pending (load issued).
REQ-016 SHALL have port pc_en / pc_sel, input, 1 / 2, PC update enable and source.
REQ-017 SHALL have port start_pc / dp_pc, input, PC_W / PC_W, reset-vector and branch-target sources.
REQ-018 SHALL have port pc_out, output, PC_W, low PC_W bits of register NREGS-1.
REQ-019 SHALL have port dbg_addr / dbg_data, input ADDR_W / output DATA_W, unbypassed debug read.

Function
REQ-020 SHALL return rd_data[i] = reg[rd_addr[i]] combinationally, zero-cycle latency.
REQ-021 SHALL, when BYPASS=1 and a same-cycle enabled write targets rd_addr[i], return that write's data (highest-priority writer); BYPASS=0 returns stored value.
REQ-022 SHALL commit every enabled write at the clock edge; on same-address collision the higher-indexed port wins.
REQ-023 SHALL on pc_en update register NREGS-1: pc_sel 01 -> start_pc, 11 -> dp_pc, 00/10 -> pc_out+1 modulo 2^PC_W; upper DATA_W-PC_W bits cleared.
REQ-024 SHALL give pc_en priority over any write port targeting NREGS-1 in the same cycle.
REQ-025 SHALL hold PC unchanged when pc_en=0 and no port writes NREGS-1.
REQ-026 SHALL keep one pending bit per register: set by rsv_en at rsv_addr, cleared by wr_en[NWR-1] at wr_addr[NWR-1].
REQ-027 SHALL, on simultaneous set and clear of the same register, leave pending=1 (new load wins).
REQ-028 SHALL drive rd_busy[i] = pending[rd_addr[i]] AND NOT (BYPASS and same-cycle load-return clearing it).
REQ-029 SHALL ignore writes from ports 0..NWR-2 for scoreboard purposes (no clear).
REQ-030 SHALL not bypass or flag dbg_data; it reads the stored value only.

Reset
REQ-031 SHALL on rst_n low asynchronously clear all registers, all pending bits, and thus pc_out to 0.
REQ-032 SHALL abandon any in-flight reservation at reset; a load-return in the first post-reset cycle writes data but pending stays 0.
REQ-033 SHALL act on inputs from the first rising clk after rst_n deasserts.

Structure
REQ-034 SHALL place pc_sel encodings (PC_INC=00, PC_START=01, PC_BRANCH=11) and default parameter constants in package regfile_pkg.
REQ-035 SHALL implement the pending-bit array and rd_busy logic as sub-module regfile_scoreboard.
REQ-036 SHALL contain no latches; storage is flops only.

Verification
REQ-037 SHALL test: reset, pc_en=1 sel=01 start_pc=0x040 -> pc_out=0x040; three cycles sel=00 -> 0x043; PC_W=11 at 0x7FF, sel=00 -> 0x000.
REQ-038 SHALL test: wr port0 and port2 both to R3 (0x11, 0x22) -> R3=0x22 next cycle; same-cycle rd_addr=3 shows 0x22 (BYPASS=1), old value (BYPASS=0).
REQ-039 SHALL test: rsv R5, next cycle rd_busy=1 for rd_addr=5; port2 writes R5=0xAB -> rd_busy=0 same cycle, rd_data=0xAB.
REQ-040 SHALL test: rsv R5 and load-return R5 same cycle -> pending remains 1 next cycle.
REQ-041 SHALL test: port1 writes R15=0x123 with pc_en sel=11 dp_pc=0x200 -> pc_out=0x200.
REQ-042 SHALL test: rst_n asserted mid-cycle with R2 pending and R2=0x55 -> R2=0, rd_busy=0 immediately, without clock.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register file: default geometry and the PC source
// select encodings.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;
  localparam int DEF_NRD    = 4;
  localparam int DEF_NWR    = 3;
  localparam int DEF_PC_W   = 11;
  localparam int DEF_BYPASS = 1;

  // PC source select. 2'b10 is not named and falls through to increment.
  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_START  = 2'b01,
    PC_BRANCH = 2'b11
  } pc_sel_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load is issued and
// cleared when the load-return port writes that register. Per-read-port busy
// flags see through a same-cycle load return when forwarding is enabled.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  parameter  int BYPASS = DEF_BYPASS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rsv_en_i,
  input  logic [ADDR_W-1:0]          rsv_addr_i,
  input  logic                       clr_en_i,
  input  logic [ADDR_W-1:0]          clr_addr_i,
  input  logic [NRD-1:0][ADDR_W-1:0] rd_addr_i,
  output logic [NRD-1:0]             rd_busy_o
);

  logic [NREGS-1:0] pend_q, pend_d;

  // Next pending state: a new reservation beats a same-cycle clear.
  always_comb begin
    pend_d = pend_q;
    for (int r = 0; r < NREGS; r++) begin
      if (clr_en_i && (clr_addr_i == ADDR_W'(r))) pend_d[r] = 1'b0;
      if (rsv_en_i && (rsv_addr_i == ADDR_W'(r))) pend_d[r] = 1'b1;
    end
  end

  // Pending bit storage; reset drops any in-flight reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Busy per read lane, masked by a load return that lands this cycle.
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic ret_hit;
    assign ret_hit      = (BYPASS != 0) && clr_en_i && (clr_addr_i == rd_addr_i[i]);
    assign rd_busy_o[i] = pend_q[rd_addr_i[i]] && !ret_hit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with zero-latency reads, optional write-to-read
// forwarding, a PC held in the top register, and a pending-load scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = DEF_NRD,
  parameter  int NWR    = DEF_NWR,
  parameter  int PC_W   = DEF_PC_W,
  parameter  int BYPASS = DEF_BYPASS,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  input  logic                  pc_en,
  input  logic [1:0]            pc_sel,
  input  logic [PC_W-1:0]       start_pc,
  input  logic [PC_W-1:0]       dp_pc,
  output logic [PC_W-1:0]       pc_out,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int PC_REG = NREGS - 1;
  localparam int RET    = NWR - 1;   // load-return write port

  logic [NWR-1:0][ADDR_W-1:0] wa;
  logic [NWR-1:0][DATA_W-1:0] wd;
  logic [NRD-1:0][ADDR_W-1:0] ra;
  logic [NRD-1:0][DATA_W-1:0] rd_val;

  assign wa      = wr_addr;
  assign wd      = wr_data;
  assign ra      = rd_addr;
  assign rd_data = rd_val;

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [PC_W-1:0]              pc_nxt;

  assign pc_out   = regs_q[PC_REG][PC_W-1:0];
  assign dbg_data = regs_q[dbg_addr];

  // PC source mux; unnamed select 2'b10 increments like PC_INC.
  always_comb begin
    case (pc_sel)
      PC_START:  pc_nxt = start_pc;
      PC_BRANCH: pc_nxt = dp_pc;
      default:   pc_nxt = pc_out + PC_W'(1);
    endcase
  end

  // Commit writes in port order so the higher port wins a collision, then
  // let a PC update override any port write to the PC register.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) regs_d[wa[p]] = wd[p];
    end
    if (pc_en) regs_d[PC_REG] = DATA_W'(pc_nxt);
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  // Read lanes: stored value, replaced by the highest-indexed same-cycle
  // writer to the same address when forwarding is enabled.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [DATA_W-1:0] lane_val;
    always_comb begin
      lane_val = regs_q[ra[i]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wa[p] == ra[i])) lane_val = wd[p];
        end
      end
    end
    assign rd_val[i] = lane_val;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .clr_en_i   (wr_en[RET]),
    .clr_addr_i (wa[RET]),
    .rd_addr_i  (ra),
    .rd_busy_o  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share one
// stimulus stream; an array/bit model built from the behavioural rules is
// compared on every falling edge, and directed steps pin literal values.
module tb_regfile_sb;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [2:0]            wr_en;
  logic [2:0][3:0]       wa;
  logic [2:0][31:0]      wd;
  logic [3:0][3:0]       ra;
  logic                  rsv_en;
  logic [3:0]            rsv_addr;
  logic                  pc_en;
  logic [1:0]            pc_sel;
  logic [10:0]           start_pc, dp_pc;
  logic [3:0]            dbg_addr;

  logic [3:0][31:0] rd1, rd0;
  logic [3:0]       busy1, busy0;
  logic [10:0]      pc1, pc0;
  logic [31:0]      dbg1, dbg0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_addr(ra), .rd_data(rd1), .rd_busy(busy1), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pc_en(pc_en), .pc_sel(pc_sel), .start_pc(start_pc),
    .dp_pc(dp_pc), .pc_out(pc1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
  );

  regfile_sb #(.BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wa), .wr_data(wd),
    .rd_addr(ra), .rd_data(rd0), .rd_busy(busy0), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pc_en(pc_en), .pc_sel(pc_sel), .start_pc(start_pc),
    .dp_pc(dp_pc), .pc_out(pc0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // ---------------- model ----------------
  bit [31:0] mreg [16];
  bit        mpend [16];

  function automatic logic [10:0] pc_next(input logic [1:0] sel, input logic [10:0] cur,
                                          input logic [10:0] st, input logic [10:0] br);
    if (sel == 2'b01)      return st;
    else if (sel == 2'b11) return br;
    else                   return cur + 11'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) begin
        mreg[r]  <= '0;
        mpend[r] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 3; p++)
        if (wr_en[p]) mreg[wa[p]] <= wd[p];
      if (pc_en) mreg[15] <= {21'b0, pc_next(pc_sel, mreg[15][10:0], start_pc, dp_pc)};
      if (wr_en[2]) mpend[wa[2]] <= 1'b0;
      if (rsv_en)   mpend[rsv_addr] <= 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e0, e1;
      logic        b0, b1;
      e0 = mreg[ra[i]];
      e1 = e0;
      for (int p = 0; p < 3; p++)
        if (wr_en[p] && wa[p] == ra[i]) e1 = wd[p];
      b0 = mpend[ra[i]];
      b1 = b0 && !(wr_en[2] && wa[2] == ra[i]);
      chk($sformatf("m_rd1_%0d", i), rd1[i], e1);
      chk($sformatf("m_rd0_%0d", i), rd0[i], e0);
      chk($sformatf("m_busy1_%0d", i), {31'b0, busy1[i]}, {31'b0, b1});
      chk($sformatf("m_busy0_%0d", i), {31'b0, busy0[i]}, {31'b0, b0});
    end
    chk("m_pc1", {21'b0, pc1}, {21'b0, mreg[15][10:0]});
    chk("m_pc0", {21'b0, pc0}, {21'b0, mreg[15][10:0]});
    chk("m_dbg1", dbg1, mreg[dbg_addr]);
    chk("m_dbg0", dbg0, mreg[dbg_addr]);
  end

  // ---------------- directed stimulus ----------------
  task automatic idle();
    wr_en = '0; wa = '0; wd = '0; ra = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    pc_en = 1'b0; pc_sel = '0; start_pc = '0; dp_pc = '0;
    dbg_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk("rst_pc", {21'b0, pc1}, 32'h0);
    dbg_addr = 4'd15; ra[0] = 4'd7;
    #1;
    chk("rst_dbg", dbg1, 32'h0);
    chk("rst_busy", {28'b0, busy1}, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    // PC load, increment, wrap
    pc_en = 1'b1; pc_sel = 2'b01; start_pc = 11'h040;
    tick(); idle(); chk("pc_start", {21'b0, pc1}, 32'h040);
    repeat (3) begin pc_en = 1'b1; pc_sel = 2'b00; tick(); end
    idle(); chk("pc_inc3", {21'b0, pc1}, 32'h043);
    pc_en = 1'b1; pc_sel = 2'b01; start_pc = 11'h7FF;
    tick(); idle(); chk("pc_7ff", {21'b0, pc1}, 32'h7FF);
    pc_en = 1'b1; pc_sel = 2'b10;
    tick(); idle(); chk("pc_wrap", {21'b0, pc1}, 32'h000);

    // write collision and forwarding
    wr_en = 3'b010; wa[1] = 4'd3; wd[1] = 32'h77;
    tick(); idle();
    wr_en = 3'b101; wa[0] = 4'd3; wd[0] = 32'h11; wa[2] = 4'd3; wd[2] = 32'h22; ra[0] = 4'd3;
    #1;
    chk("col_byp", rd1[0], 32'h22);
    chk("col_nobyp", rd0[0], 32'h77);
    tick(); idle(); ra[0] = 4'd3; dbg_addr = 4'd3;
    #1;
    chk("col_commit", rd0[0], 32'h22);
    chk("col_dbg", dbg1, 32'h22);

    // reservation then load return
    rsv_en = 1'b1; rsv_addr = 4'd5;
    tick(); idle(); ra[1] = 4'd5;
    #1;
    chk("rsv_busy1", {31'b0, busy1[1]}, 32'h1);
    chk("rsv_busy0", {31'b0, busy0[1]}, 32'h1);
    wr_en = 3'b100; wa[2] = 4'd5; wd[2] = 32'hAB;
    #1;
    chk("ret_busy_byp", {31'b0, busy1[1]}, 32'h0);
    chk("ret_data_byp", rd1[1], 32'hAB);
    chk("ret_busy_nobyp", {31'b0, busy0[1]}, 32'h1);
    chk("ret_data_nobyp", rd0[1], 32'h0);
    tick(); idle(); ra[1] = 4'd5;
    #1;
    chk("ret_cleared", {31'b0, busy0[1]}, 32'h0);

    // simultaneous set and clear: new load wins
    rsv_en = 1'b1; rsv_addr = 4'd5; wr_en = 3'b100; wa[2] = 4'd5; wd[2] = 32'hCD;
    tick(); idle(); ra[1] = 4'd5;
    #1;
    chk("setclr_busy", {31'b0, busy0[1]}, 32'h1);
    chk("setclr_data", rd0[1], 32'hCD);

    // PC update beats a port write to the PC register
    wr_en = 3'b010; wa[1] = 4'd15; wd[1] = 32'h123;
    pc_en = 1'b1; pc_sel = 2'b11; dp_pc = 11'h200;
    tick(); idle(); dbg_addr = 4'd15;
    #1;
    chk("pc_prio", {21'b0, pc1}, 32'h200);
    chk("pc_prio_reg", dbg1, 32'h200);

    // plain port write to the PC register, then increment clears upper bits
    wr_en = 3'b001; wa[0] = 4'd15; wd[0] = 32'hABCD_E456;
    tick(); idle(); chk("pc_portwr", {21'b0, pc1}, 32'h456);
    pc_en = 1'b1; pc_sel = 2'b00;
    tick(); idle(); dbg_addr = 4'd15;
    #1;
    chk("pc_upper_clr", dbg1, 32'h457);

    // asynchronous reset mid-cycle with R2 pending
    rsv_en = 1'b1; rsv_addr = 4'd2; wr_en = 3'b001; wa[0] = 4'd2; wd[0] = 32'h55;
    tick(); idle(); ra[2] = 4'd2; dbg_addr = 4'd2;
    #1;
    chk("pre_rst_busy", {31'b0, busy1[2]}, 32'h1);
    chk("pre_rst_dbg", dbg1, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data", rd1[2], 32'h0);
    chk("arst_busy", {31'b0, busy1[2]}, 32'h0);
    chk("arst_dbg", dbg1, 32'h0);
    chk("arst_pc", {21'b0, pc1}, 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // load return in first post-reset cycle: data lands, no pending
    wr_en = 3'b100; wa[2] = 4'd2; wd[2] = 32'h99;
    tick(); idle(); ra[2] = 4'd2; dbg_addr = 4'd2;
    #1;
    chk("post_rst_busy", {31'b0, busy0[2]}, 32'h0);
    chk("post_rst_data", dbg1, 32'h99);

    // mixed traffic checked by the model
    repeat (80) begin
      wr_en    = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        wa[p] = 4'($urandom);
        wd[p] = $urandom;
      end
      for (int i = 0; i < 4; i++) ra[i] = 4'($urandom);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 4'($urandom);
      pc_en    = ($urandom_range(0, 3) == 0);
      pc_sel   = 2'($urandom);
      start_pc = 11'($urandom);
      dp_pc    = 11'($urandom);
      dbg_addr = 4'($urandom);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
